// File: rtl/cpu_clock_ctrl_pkg.sv
// Shared encodings for the CPU clock-enable controller: operating modes, FSM states
// and the mode-to-state decoder used by the top level.
package cpu_clock_ctrl_pkg;

    localparam logic [1:0] ModeRun  = 2'b00;
    localparam logic [1:0] ModeHalt = 2'b01;
    localparam logic [1:0] ModeStep = 2'b10;

    typedef enum logic [1:0] {
        StRst  = 2'd0,
        StRun  = 2'd1,
        StHalt = 2'd2,
        StStep = 2'd3
    } state_e;

    // The reserved mode encoding parks the core exactly like HALT.
    function automatic state_e decode_mode(input logic [1:0] mode);
        state_e st;
        unique case (mode)
            ModeRun:  st = StRun;
            ModeStep: st = StStep;
            default:  st = StHalt;
        endcase
        return st;
    endfunction

endpackage

// File: rtl/clk_tick_gen.sv
// Free-running divide counter with a runtime-selectable power-of-two tick.
// The counter is never cleared by div_sel changes, so a new ratio takes effect within 2^k cycles.
module clk_tick_gen #(
    parameter int unsigned DIV_W = 25,
    parameter int unsigned SEL_W = $clog2(DIV_W)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [SEL_W-1:0] div_sel,
    output logic             tick
);

    logic [DIV_W-1:0] div_cnt_d, div_cnt_q;
    logic [DIV_W-1:0] mask;
    logic [SEL_W-1:0] k;

    always_comb begin
        k = div_sel;
        if (32'(div_sel) >= DIV_W) begin
            k = SEL_W'(DIV_W - 1);
        end
        for (int unsigned i = 0; i < DIV_W; i++) begin
            mask[i] = (i < 32'(k));
        end
        // With k == 0 the mask is empty and the reduction is trivially true.
        tick      = &(div_cnt_q | ~mask);
        div_cnt_d = div_cnt_q + DIV_W'(1);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            div_cnt_q <= '0;
        end else begin
            div_cnt_q <= div_cnt_d;
        end
    end

endmodule

// File: rtl/cpu_clock_ctrl.sv
// Clock-enable and CPU reset controller: issues single-cycle enables in run/halt/step modes
// on the board clock and stretches the core reset for a fixed number of cycles.
module cpu_clock_ctrl
    import cpu_clock_ctrl_pkg::*;
#(
    parameter int unsigned DIV_W      = 25,
    parameter int unsigned RST_CYCLES = 16,
    parameter int unsigned CNT_W      = 32,
    parameter int unsigned SEL_W      = $clog2(DIV_W)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [SEL_W-1:0] div_sel,
    input  logic [1:0]       mode,
    input  logic             step_btn,
    input  logic             ext_halt,
    output logic             cpu_en,
    output logic             cpu_reset,
    output logic             halted,
    output logic [CNT_W-1:0] en_count
);

    localparam int unsigned RstW = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
    localparam logic [RstW-1:0] RstLast = RstW'(RST_CYCLES - 1);

    state_e           state_d, state_q;
    logic [RstW-1:0]  rst_cnt_d, rst_cnt_q;
    logic             btn_q;
    logic             cpu_en_d, cpu_en_q;
    logic             cpu_reset_d, cpu_reset_q;
    logic             halted_d, halted_q;
    logic [CNT_W-1:0] en_count_d, en_count_q;
    logic             tick;
    logic             step_edge;

    clk_tick_gen #(
        .DIV_W (DIV_W),
        .SEL_W (SEL_W)
    ) u_tick_gen (
        .clk     (clk),
        .reset   (reset),
        .div_sel (div_sel),
        .tick    (tick)
    );

    assign step_edge = step_btn & ~btn_q;

    always_comb begin
        state_d     = state_q;
        rst_cnt_d   = rst_cnt_q;
        cpu_en_d    = 1'b0;
        cpu_reset_d = 1'b0;
        halted_d    = 1'b1;

        unique case (state_q)
            StRst: begin
                cpu_reset_d = 1'b1;
                if (rst_cnt_q == RstLast) begin
                    state_d     = decode_mode(mode);
                    cpu_reset_d = 1'b0;
                end else begin
                    rst_cnt_d = rst_cnt_q + RstW'(1);
                end
            end
            StRun: begin
                state_d  = decode_mode(mode);
                cpu_en_d = tick & ~ext_halt;
                halted_d = ext_halt;
            end
            StHalt: begin
                state_d = decode_mode(mode);
            end
            StStep: begin
                // Steps bypass both the divider and the core's own halt request.
                state_d  = decode_mode(mode);
                cpu_en_d = step_edge;
            end
            default: begin
                state_d = StRst;
            end
        endcase

        en_count_d = en_count_q + CNT_W'(cpu_en_d);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= StRst;
            rst_cnt_q   <= '0;
            btn_q       <= 1'b0;
            cpu_en_q    <= 1'b0;
            cpu_reset_q <= 1'b1;
            halted_q    <= 1'b1;
            en_count_q  <= '0;
        end else begin
            state_q     <= state_d;
            rst_cnt_q   <= rst_cnt_d;
            btn_q       <= step_btn;
            cpu_en_q    <= cpu_en_d;
            cpu_reset_q <= cpu_reset_d;
            halted_q    <= halted_d;
            en_count_q  <= en_count_d;
        end
    end

    assign cpu_en    = cpu_en_q;
    assign cpu_reset = cpu_reset_q;
    assign halted    = halted_q;
    assign en_count  = en_count_q;

endmodule
